uart_echo_tester: RTL

Self-checking UART link partner for the echo path of the UART top level: it transmits a programmable incrementing byte pattern on its own serial output and receives the echoed bytes on its serial input. Each echo is compared against the byte sent, and mismatches, framing errors and timeouts are counted. It sits on the far end of the DUT's `rx`/`tx` pins, in lab builds or as a bench-side synthesizable checker, and runs from the system clock with its own bit timing.

---
 rtl/uart_echo_tester.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_tester.sv
// UART echo-path link partner: sends an incrementing byte pattern on tx and checks
// that each byte comes back on rx, counting mismatches, framing errors and timeouts.
module uart_echo_tester #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_BITS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] num_bytes,
  input  logic [7:0] seed,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  localparam int unsigned ToCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned ToW      = $clog2(ToCycles + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(ToCycles - 1);

  typedef enum logic [2:0] {StIdle, StSend, StWaitEcho, StCheck, StFinish} state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

  state_e          state_q;
  logic            tx_q, busy_q, done_q, pass_q, timeout_q;
  logic [7:0]      err_q, byte_q;
  logic [8:0]      left_q;
  logic [3:0]      bit_idx_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [ToW-1:0]  to_cnt_q;

  rx_state_e       rx_state_q;
  logic [1:0]      rx_sync_q;
  logic            rx_prev_q, frame_err_q, pend_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q, rx_byte_q;

  logic       rx_s, byte_err, more, send_entry;
  logic [7:0] err_nxt;

  assign rx_s       = rx_sync_q[1];
  assign byte_err   = timeout_q | frame_err_q | (rx_byte_q != byte_q);
  assign err_nxt    = (byte_err && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  assign more       = (left_q != 9'd1);
  assign send_entry = ((state_q == StIdle) && start) || ((state_q == StCheck) && more);

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 8'd0;
      byte_q    <= 8'd0;
      left_q    <= 9'd0;
      bit_idx_q <= 4'd0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            byte_q    <= seed;
            left_q    <= (num_bytes == 8'd0) ? 9'd256 : {1'b0, num_bytes};
            err_q     <= 8'd0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b1;
            tx_q      <= 1'b0;
            bit_idx_q <= 4'd0;
            bit_cnt_q <= '0;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (bit_cnt_q == BitLast) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 4'd9) begin
              to_cnt_q  <= '0;
              timeout_q <= 1'b0;
              state_q   <= StWaitEcho;
            end else begin
              // Slot bit_idx+1 carries data bit bit_idx; slot 9 is the stop bit.
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= (bit_idx_q == 4'd8) ? 1'b1 : byte_q[bit_idx_q[2:0]];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
        end
        StWaitEcho: begin
          if (pend_q) begin
            state_q <= StCheck;
          end else if (to_cnt_q == ToLast) begin
            timeout_q <= 1'b1;
            state_q   <= StCheck;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        StCheck: begin
          err_q  <= err_nxt;
          byte_q <= byte_q + 8'd1;
          left_q <= left_q - 9'd1;
          if (more) begin
            tx_q      <= 1'b0;
            bit_idx_q <= 4'd0;
            bit_cnt_q <= '0;
            state_q   <= StSend;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_nxt == 8'd0);
            state_q <= StFinish;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Receiver runs continuously so an echo overlapping our own stop bit is still caught.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_q   <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      rx_byte_q   <= 8'd0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
      rx_prev_q <= rx_s;
      if (send_entry) pend_q <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_s) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxStart;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_state_q <= rx_s ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxData: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxStop: begin
          if (rx_cnt_q == BitLast) begin
            rx_cnt_q    <= '0;
            rx_byte_q   <= rx_shift_q;
            frame_err_q <= !rx_s;
            if ((state_q != StIdle) && !send_entry) pend_q <= 1'b1;
            rx_state_q  <= rx_s ? RxIdle : RxWaitHigh;
          end else begin
            rx_cnt_q <= rx_cnt_q + CntW'(1);
          end
        end
        RxWaitHigh: if (rx_s) rx_state_q <= RxIdle;
        default:    rx_state_q <= RxIdle;
      endcase
    end
  end

endmodule
